// File: rtl/synapse_current.sv
// ---------------------------------------------------------------------------
// synapse_current
//
// Event-driven synaptic current generator feeding the Izhikevich integrator.
// Presynaptic spike events, each tagged with a synapse id, are queued in a
// small FIFO. On every timestep strobe the queued events are drained one per
// cycle, adding each synapse weight into a saturating signed Q16.16
// accumulator. The accumulator is then decayed exponentially and published
// as the next synaptic current.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   step       timestep strobe, one cycle per dt
//   spk_valid  spike event valid
//   spk_id     synapse index of the spike
//   spk_ready  FIFO can accept an event (only while idle and not full)
//   wr_en      weight write strobe
//   wr_addr    weight index
//   wr_data    signed Q16.16 weight
//   I_out      signed synaptic current, holds between publishes
//   I_valid    one-cycle pulse when I_out updates
//   busy       step processing in progress
//   overrun    sticky: a step arrived while busy
// ---------------------------------------------------------------------------
module synapse_current #(
    parameter int N         = 32,
    parameter int NSYN      = 8,
    parameter int DEPTH     = 4,
    parameter int TAU_SHIFT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    step,
    input  logic                    spk_valid,
    input  logic [$clog2(NSYN)-1:0] spk_id,
    output logic                    spk_ready,
    input  logic                    wr_en,
    input  logic [$clog2(NSYN)-1:0] wr_addr,
    input  logic [N-1:0]            wr_data,
    output logic [N-1:0]            I_out,
    output logic                    I_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int IDW = $clog2(NSYN);
    localparam int AW  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        DECAY   = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic        [AW:0]     wr_ptr_q, rd_ptr_q;
    logic        [IDW-1:0]  fifo_q   [DEPTH];
    logic        [N-1:0]    weight_q [NSYN];
    logic signed [N-1:0]    acc_q, acc_d;
    logic        [N-1:0]    iout_q, iout_d;
    logic                   overrun_q, overrun_d;

    logic                   empty, full, push, pop, lastPop;
    logic        [AW:0]     occupancy;
    logic signed [N-1:0]    popWeight;
    logic signed [N-1:0]    decayed;

    // Saturating signed add: overflow shows up as disagreement between the
    // sign-extension bit and the result sign bit of the widened sum.
    function automatic logic signed [N-1:0] satAdd(input logic signed [N-1:0] a,
                                                   input logic signed [N-1:0] b);
        logic signed [N:0] sum;
        sum = {a[N-1], a} + {b[N-1], b};
        if (sum[N] != sum[N-1]) begin
            if (sum[N]) begin
                satAdd = {1'b1, {(N-1){1'b0}}};
            end else begin
                satAdd = {1'b0, {(N-1){1'b1}}};
            end
        end else begin
            satAdd = sum[N-1:0];
        end
    endfunction

    // The extra pointer bit distinguishes full from empty when the low
    // address bits coincide.
    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign spk_ready = !full && (state_q == IDLE);
    assign push      = spk_valid && spk_ready;
    assign pop       = (state_q == DRAIN) && !empty;
    assign lastPop   = (occupancy <= (AW+1)'(1));

    // Reading the registered weight array means a same-cycle write to the
    // same address only becomes visible to later drains.
    assign popWeight = $signed(weight_q[fifo_q[rd_ptr_q[AW-1:0]]]);

    // Arithmetic shift rounds toward -inf; the difference never leaves range.
    assign decayed   = acc_q - (acc_q >>> TAU_SHIFT);

    assign I_out   = iout_q;
    assign I_valid = (state_q == PUBLISH);
    assign busy    = (state_q != IDLE);
    assign overrun = overrun_q;

    // Next-state, accumulator and publish logic.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        iout_d    = iout_q;
        overrun_d = overrun_q;

        if (step && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // A push in the step cycle lands in the FIFO and is drained.
                if (step) begin
                    state_d = (!empty || push) ? DRAIN : DECAY;
                end
            end
            DRAIN: begin
                if (pop) begin
                    acc_d = satAdd(acc_q, popWeight);
                end
                if (lastPop) begin
                    state_d = DECAY;
                end
            end
            DECAY: begin
                // I_out is loaded here so it is already valid while the
                // PUBLISH cycle raises I_valid.
                acc_d   = decayed;
                iout_d  = decayed;
                state_d = PUBLISH;
            end
            PUBLISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            acc_q     <= '0;
            iout_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            iout_q    <= iout_d;
            overrun_q <= overrun_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // FIFO payload needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= spk_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSYN; i++) begin
                weight_q[i] <= '0;
            end
        end else if (wr_en) begin
            weight_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: doc/synapse_current.md
Name: synapse_current

Overview:
- Event-driven synaptic current generator; produces the input current I consumed by the Izhikevich integrator.
- Queues presynaptic spike events, each tagged with a synapse id, from upstream neuron fire outputs.
- On every timestep strobe it:
  - sums the programmed weights of all queued spikes into a signed Q16.16 current accumulator;
  - applies exponential decay;
  - publishes the result as the next I.

Parameters:
- N, 32, data width; Q(N/2).(N/2) fixed point, so 1.0 = 32'h0001_0000.
- NSYN, 8, number of synapses (weight entries).
- DEPTH, 4, spike event FIFO depth (power of two, ≥2).
- TAU_SHIFT, 3, decay shift; per step, I -= I >>> TAU_SHIFT.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- step  in  1  timestep strobe, one cycle per dt.
- spk_valid  in  1  spike event valid.
- spk_id  in  $clog2(NSYN)  synapse index of the spike.
- spk_ready  out  1  FIFO can accept an event.
- wr_en  in  1  weight write strobe.
- wr_addr  in  $clog2(NSYN)  weight index.
- wr_data  in  N  signed weight, Q16.16.
- I_out  out  N  signed synaptic current to the integrator.
- I_valid  out  1  one-cycle pulse when I_out updates.
- busy  out  1  step processing in progress.
- overrun  out  1  sticky flag: step arrived while busy.

Behaviour:
- Reset (async, rst_n=0) clears:
  - FIFO empty, spk_ready=1;
  - accumulator = 0, I_out = 0;
  - I_valid=0, busy=0, overrun=0;
  - all weights = 0;
  - state = IDLE.
- Reset mid-step aborts processing; nothing is published.
- Spike push: a transfer occurs on a rising edge with spk_valid & spk_ready. spk_ready = !full & (state==IDLE).
- FIFO full: spk_ready=0 and the event is held by the sender; no drop.
- Weight write: takes effect on the next edge and is allowed in any state. If a write and a drain read hit the same address in the same cycle, the drain uses the old weight.
- States:
  - IDLE: on step, go to DRAIN (busy=1). A push in that same cycle is accepted and counted in this step.
  - DRAIN: pop one event per cycle; acc = sat(acc + w[id]). Exit to DECAY when the FIFO is empty; an empty FIFO spends 0 drain cycles (IDLE goes straight to DECAY).
  - DECAY: acc = acc - (acc >>> TAU_SHIFT), arithmetic shift with truncation toward -inf. The result is always in range; no saturation needed.
  - PUBLISH: I_out <= acc; I_valid=1 for this cycle only; then go to IDLE with busy=0.
- Latency: the step edge to I_valid takes k + 2 cycles, where k is the FIFO occupancy at step.
- Saturating add: on positive overflow clamp to 0x7FFF_FFFF; on negative overflow clamp to 0x8000_0000.
- step while busy: the step is ignored and overrun is set; it stays set until reset.
- I_out holds its value between publishes.
- FIFO pointers wrap modulo DEPTH. Full/empty use an extra pointer bit.

Test Plan:
- Basic accumulate: w[2] = 0x0001_0000, push id 2 three times, pulse step → I_valid 5 cycles after step, I_out = 0x0002_A000 (2.625).
- Negative weight: w[5] = 0xFFFF_0000, one spike on id 5, step → I_out = 0xFFFF_2000 (-0.875).
- Saturation: w[0] = 0x7000_0000, two spikes, step → acc clamps to 0x7FFF_FFFF, I_out = 0x7000_0000 after decay.
- Backpressure:
  - Hold spk_valid with no step: 4 events accepted, then spk_ready=0 and the 5th event is stalled.
  - step → drain runs with spk_ready=0.
  - After PUBLISH, spk_ready=1 and the 5th event is accepted.
- Decay only: with I_out = 0x0008_0000, three steps with no spikes → 0x0007_0000, 0x0006_2000, 0x0005_5C00; each step with an empty FIFO gives I_valid 2 cycles after step.
- Overrun and reset:
  - A step during DRAIN sets overrun=1 and the step count is unchanged.
  - rst_n=0 mid-DRAIN clears I_out, FIFO, weights and overrun immediately, with no I_valid pulse.
